posit_unpack: RTL and testbench

- Multi-precision posit decoder at the FMA front end; the inverse of the packing/rounding stage.
- Splits a 32-bit operand word into 4x posit8 (es=0), 2x posit16 (es=1) or 1x posit32 (es=2), selected by in_pre.
- Per lane it produces sign, scale and a normalized mantissa, in the exact s/exp/mant field layout the packing stage consumes.
- Two-stage pipeline with valid/ready handshake on both sides.

---
 rtl/posit_pkg.sv | 33 +++
 rtl/posit_run_detect.sv | 23 ++
 rtl/posit_unpack.sv | 197 +++++++++++++++++++
 tb/tb_posit_unpack.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared posit format constants and the regime/exponent-to-scale helper
// used by the multi-precision unpack stage.
package posit_pkg;

  localparam logic [1:0] PRE_P8X4  = 2'b00;
  localparam logic [1:0] PRE_P16X2 = 2'b01;
  localparam logic [1:0] PRE_P32   = 2'b10;

  localparam int ES_P8  = 0;
  localparam int ES_P16 = 1;
  localparam int ES_P32 = 2;

  localparam int W_P8  = 8;
  localparam int W_P16 = 16;
  localparam int W_P32 = 32;

  localparam int EXP_W_P8  = 5;
  localparam int EXP_W_P16 = 10;
  localparam int EXP_W_P32 = 20;

  localparam int MANT_W_P8  = 17;
  localparam int MANT_W_P16 = 34;
  localparam int MANT_W_P32 = 68;

  // A run of ones of length m gives k = m-1; a run of zeros gives k = -m.
  function automatic logic [19:0] regime_scale(input logic pol, input logic [4:0] run,
                                               input logic [1:0] e, input int es);
    logic [19:0] k;
    k = pol ? 20'(run) - 20'd1 : 20'd0 - 20'(run);
    return (k << es) + 20'(e);
  endfunction

endpackage

// File: rtl/posit_run_detect.sv
// Leading-run counter: number of bits from the MSB down that equal the MSB
// (W when the whole body is one run).
module posit_run_detect #(
  parameter int W  = 7,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  body,
  output logic [CW-1:0] run_len
);

  always_comb begin
    logic found;
    run_len = CW'(W);
    found   = 1'b0;
    for (int i = W - 2; i >= 0; i--) begin
      if (!found && (body[i] != body[W-1])) begin
        run_len = CW'(W - 1 - i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/posit_unpack.sv
// Posit decoder front end: splits a 32-bit word into p8x4 / p16x2 / p32 lanes
// and emits sign, scale and left-aligned mantissa per lane over two stages.
module posit_unpack
  import posit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_pre,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_pre,
  output logic [3:0]  s,
  output logic [19:0] exp,
  output logic [67:0] mant,
  output logic [3:0]  zero,
  output logic [3:0]  nar
);

  // Valid/ready: a word moves when valid & ready are both high. A stage advances
  // when it is empty or the stage after it advances, so in_ready follows out_ready
  // combinationally and one word per cycle streams through with no bubbles.
  logic v1, v2, adv1, adv2;
  assign adv2      = ~v2 | out_ready;
  assign adv1      = ~v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  logic [7:0]  abs8  [4];
  logic [15:0] abs16 [2];
  logic [31:0] abs32;
  logic [2:0]  run8  [4];
  logic [3:0]  run16 [2];
  logic [4:0]  run32;

  always_comb begin
    for (int i = 0; i < 4; i++)
      abs8[i] = in_data[8*i+7] ? 8'd0 - in_data[8*i +: 8] : in_data[8*i +: 8];
    for (int j = 0; j < 2; j++)
      abs16[j] = in_data[16*j+15] ? 16'd0 - in_data[16*j +: 16] : in_data[16*j +: 16];
    abs32 = in_data[31] ? 32'd0 - in_data : in_data;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_p8
    posit_run_detect #(.W(W_P8 - 1)) u_run (.body(abs8[gi][6:0]), .run_len(run8[gi]));
  end
  for (genvar gj = 0; gj < 2; gj++) begin : g_p16
    posit_run_detect #(.W(W_P16 - 1)) u_run (.body(abs16[gj][14:0]), .run_len(run16[gj]));
  end
  posit_run_detect #(.W(W_P32 - 1)) u_run_p32 (.body(abs32[30:0]), .run_len(run32));

  // Stage-1 capture values, selected by the incoming precision
  logic [31:0] abs_d;
  logic [4:0]  run_d [4];
  logic [3:0]  sgn_d, zero_d, nar_d;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      abs_d[8*i +: 8] = abs8[i];
      run_d[i]        = 5'(run8[i]);
      sgn_d[i]        = in_data[8*i+7];
      zero_d[i]       = (in_data[8*i +: 8] == 8'h00);
      nar_d[i]        = (in_data[8*i +: 8] == 8'h80);
    end
    case (in_pre)
      PRE_P16X2: begin
        for (int j = 0; j < 2; j++) begin
          abs_d[16*j +: 16] = abs16[j];
          run_d[j]          = 5'(run16[j]);
          run_d[j+2]        = '0;
          sgn_d[2*j +: 2]   = {2{in_data[16*j+15]}};
          zero_d[2*j +: 2]  = {2{in_data[16*j +: 16] == 16'h0000}};
          nar_d[2*j +: 2]   = {2{in_data[16*j +: 16] == 16'h8000}};
        end
      end
      PRE_P32: begin
        abs_d    = abs32;
        run_d[0] = run32;
        run_d[1] = '0;
        run_d[2] = '0;
        run_d[3] = '0;
        sgn_d    = {4{in_data[31]}};
        zero_d   = {4{in_data == 32'h0000_0000}};
        nar_d    = {4{in_data == 32'h8000_0000}};
      end
      default: ;
    endcase
  end

  logic [1:0]  pre_q;
  logic [31:0] abs_q;
  logic [4:0]  run_q [4];
  logic [3:0]  sgn_q, zero_q, nar_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      pre_q  <= '0;
      abs_q  <= '0;
      run_q  <= '{default: '0};
      sgn_q  <= '0;
      zero_q <= '0;
      nar_q  <= '0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv1 && in_valid) begin
        pre_q  <= in_pre;
        abs_q  <= abs_d;
        run_q  <= run_d;
        sgn_q  <= sgn_d;
        zero_q <= zero_d;
        nar_q  <= nar_d;
      end
    end
  end

  // abs MSBs of the p16 and p32 lanes are only non-zero for NaR, which is flagged separately
  logic unused_abs_msb;
  assign unused_abs_msb = ^{abs_q[31], abs_q[15]};

  // Stage 2: drop regime and terminator, then split exponent and fraction
  logic [19:0] exp8, exp16, exp32, exp_n;
  logic [67:0] mant8, mant16, mant32, mant_n;

  always_comb begin
    exp8  = '0;
    mant8 = '0;
    for (int i = 0; i < 4; i++) begin
      logic [6:0] body, rem;
      body = abs_q[8*i +: 7];
      rem  = body << (6'(run_q[i]) + 6'd1);
      if (!(zero_q[i] || nar_q[i])) begin
        exp8[5*i +: 5]    = 5'(regime_scale(body[6], run_q[i], 2'd0, ES_P8));
        mant8[17*i +: 17] = {1'b1, rem, 9'd0};
      end
    end
  end

  always_comb begin
    exp16  = '0;
    mant16 = '0;
    for (int j = 0; j < 2; j++) begin
      logic [14:0] body, rem;
      body = abs_q[16*j +: 15];
      rem  = body << (6'(run_q[j]) + 6'd1);
      if (!(zero_q[2*j] || nar_q[2*j])) begin
        exp16[10*j +: 10]  = 10'(regime_scale(body[14], run_q[j], {1'b0, rem[14]}, ES_P16));
        mant16[34*j +: 34] = {1'b1, rem[13:0], 19'd0};
      end
    end
  end

  always_comb begin
    logic [30:0] body, rem;
    body   = abs_q[30:0];
    rem    = body << (6'(run_q[0]) + 6'd1);
    exp32  = '0;
    mant32 = '0;
    if (!(zero_q[0] || nar_q[0])) begin
      exp32  = regime_scale(body[30], run_q[0], rem[30:29], ES_P32);
      mant32 = {1'b1, rem[28:0], 38'd0};
    end
  end

  always_comb begin
    case (pre_q)
      PRE_P16X2: begin exp_n = exp16; mant_n = mant16; end
      PRE_P32:   begin exp_n = exp32; mant_n = mant32; end
      default:   begin exp_n = exp8;  mant_n = mant8;  end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2      <= 1'b0;
      out_pre <= '0;
      s       <= '0;
      exp     <= '0;
      mant    <= '0;
      zero    <= '0;
      nar     <= '0;
    end else begin
      if (adv2) v2 <= v1;
      if (adv2 && v1) begin
        out_pre <= pre_q;
        s       <= sgn_q;
        exp     <= exp_n;
        mant    <= mant_n;
        zero    <= zero_q;
        nar     <= nar_q;
      end
    end
  end

endmodule

// File: tb/tb_posit_unpack.sv
// Self-checking bench for posit_unpack: directed vectors, back-pressure,
// randomized streaming against a posit-definition model, and mid-stream reset.
module tb_posit_unpack;
  import posit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_pre = 2'b00;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_pre;
  logic [3:0]  s, zero, nar;
  logic [19:0] exp;
  logic [67:0] mant;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]  pre;
    logic [3:0]  s;
    logic [19:0] exp;
    logic [67:0] mant;
    logic [3:0]  zero;
    logic [3:0]  nar;
  } res_t;
  localparam int RW = $bits(res_t);
  logic [RW-1:0] exp_q[$];

  logic [7:0]  sp8 [8] = '{8'h00, 8'h80, 8'h01, 8'h7F, 8'hFF, 8'h81, 8'h40, 8'hC0};
  logic [31:0] spw [6] = '{32'h0, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 32'h8000_8000, 32'h0000_7FFF};

  posit_unpack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pre(in_pre), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pre(out_pre), .s(s), .exp(exp), .mant(mant), .zero(zero), .nar(nar)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Walks the posit bit by bit: sign, regime run, terminator, es exponent bits, fraction.
  function automatic void model_lane(input logic [31:0] x, input int n, input int es, input int mw,
                                     output logic sg, output logic [19:0] sc, output logic [67:0] mt,
                                     output logic z, output logic nr);
    logic [31:0] mask, a;
    logic pol;
    int pos, m, k, e, nf;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    x  = x & mask;
    sg = x[n-1];
    z  = (x == 32'd0);
    nr = (x == (32'd1 << (n - 1)));
    sc = '0;
    mt = '0;
    if (z || nr) return;
    a   = sg ? ((~x + 32'd1) & mask) : x;
    pol = a[n-2];
    m   = 0;
    pos = n - 2;
    while (pos >= 0 && a[pos] == pol) begin m++; pos--; end
    k = pol ? m - 1 : -m;
    pos--;
    e = 0;
    for (int b = 0; b < es; b++) begin
      e = e * 2 + ((pos >= 0) ? int'(a[pos]) : 0);
      pos--;
    end
    nf = (pos >= 0) ? pos + 1 : 0;
    sc = 20'(k * (1 << es) + e);
    mt = (68'd1 << (mw - 1)) | ((68'(a) & ((68'd1 << nf) - 68'd1)) << (mw - 1 - nf));
  endfunction

  function automatic res_t expect_word(input logic [1:0] pre, input logic [31:0] d);
    res_t r;
    logic sg, z, nr;
    logic [19:0] sc;
    logic [67:0] mt;
    r = '0;
    r.pre = pre;
    if (pre == PRE_P16X2) begin
      for (int j = 0; j < 2; j++) begin
        model_lane(d >> (16 * j), 16, 1, 34, sg, sc, mt, z, nr);
        r.s[2*j +: 2]      = {2{sg}};
        r.exp[10*j +: 10]  = sc[9:0];
        r.mant[34*j +: 34] = mt[33:0];
        r.zero[2*j +: 2]   = {2{z}};
        r.nar[2*j +: 2]    = {2{nr}};
      end
    end else if (pre == PRE_P32) begin
      model_lane(d, 32, 2, 68, sg, sc, mt, z, nr);
      r.s = {4{sg}}; r.exp = sc; r.mant = mt; r.zero = {4{z}}; r.nar = {4{nr}};
    end else begin
      for (int i = 0; i < 4; i++) begin
        model_lane(d >> (8 * i), 8, 0, 17, sg, sc, mt, z, nr);
        r.s[i]             = sg;
        r.exp[5*i +: 5]    = sc[4:0];
        r.mant[17*i +: 17] = mt[16:0];
        r.zero[i]          = z;
        r.nar[i]           = nr;
      end
    end
    return r;
  endfunction

  function automatic res_t dut_res();
    return {out_pre, s, exp, mant, zero, nar};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    if ($urandom_range(0, 9) == 0) return spw[$urandom_range(0, 5)];
    w = $urandom;
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 5) == 0) w[8*i +: 8] = sp8[$urandom_range(0, 7)];
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting edge with in_valid low.
  task automatic send_word(input logic [1:0] pre, input logic [31:0] data, output bit acc);
    in_valid = 1'b1;
    in_pre   = pre;
    in_data  = data;
    acc      = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      #1;
      acc = in_ready;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_single(input logic [1:0] pre, input logic [31:0] data, output int lat, output bit ok);
    bit acc;
    out_ready = 1'b1;
    send_word(pre, data, acc);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    ok = acc && out_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if (dut_res() !== res_t'(0)) begin errors++; $display("FAIL reset_data: got %h want 0", dut_res()); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_p8_vector();
    int lat; bit ok;
    run_single(PRE_P8X4, 32'h8000_C040, lat, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL p8_handshake: accepted/valid got %b want 1", ok); end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL p8_latency: got %0d want 2", lat); end
    checks++;
    if (s !== 4'b1010) begin errors++; $display("FAIL p8_sign: got %b want 1010", s); end
    checks++;
    if (exp !== 20'd0) begin errors++; $display("FAIL p8_exp: got %h want 0", exp); end
    checks++;
    if (mant !== {17'h0, 17'h0, 17'h10000, 17'h10000}) begin
      errors++; $display("FAIL p8_mant: got %h want %h", mant, {17'h0, 17'h0, 17'h10000, 17'h10000});
    end
    checks++;
    if (zero !== 4'b0100 || nar !== 4'b1000) begin
      errors++; $display("FAIL p8_special: got zero=%b nar=%b want 0100 1000", zero, nar);
    end
    checks++;
    if (dut_res() !== expect_word(PRE_P8X4, 32'h8000_C040)) begin
      errors++; $display("FAIL p8_model: got %h want %h", dut_res(), expect_word(PRE_P8X4, 32'h8000_C040));
    end
    @(negedge clk);
  endtask

  task automatic test_p16_vector();
    int lat; bit ok;
    run_single(PRE_P16X2, 32'h7FFF_5000, lat, ok);
    checks++;
    if (!ok || lat != 2) begin errors++; $display("FAIL p16_latency: got ok=%b lat=%0d want 1 2", ok, lat); end
    checks++;
    if (exp !== {10'd28, 10'd1}) begin errors++; $display("FAIL p16_exp: got %h want %h", exp, {10'd28, 10'd1}); end
    checks++;
    if (mant !== {34'h200000000, 34'h200000000}) begin
      errors++; $display("FAIL p16_mant: got %h want %h", mant, {34'h200000000, 34'h200000000});
    end
    checks++;
    if (s !== 4'b0000 || zero !== 4'b0000 || nar !== 4'b0000 || out_pre !== PRE_P16X2) begin
      errors++; $display("FAIL p16_flags: got s=%b zero=%b nar=%b pre=%b want 0 0 0 01", s, zero, nar, out_pre);
    end
    @(negedge clk);
  endtask

  task automatic test_p32_minpos();
    int lat; bit ok;
    run_single(PRE_P32, 32'h0000_0001, lat, ok);
    checks++;
    if (!ok || exp !== 20'hFFF88 || mant !== 68'h80000000000000000 || s !== 4'h0 || zero !== 4'h0) begin
      errors++; $display("FAIL p32_minpos: got ok=%b s=%h exp=%h mant=%h zero=%h want 1 0 fff88 80000000000000000 0",
                         ok, s, exp, mant, zero);
    end
    @(negedge clk);
    run_single(PRE_P32, 32'hFFFF_FFFF, lat, ok);
    checks++;
    if (!ok || exp !== 20'hFFF88 || mant !== 68'h80000000000000000 || s !== 4'hF || nar !== 4'h0) begin
      errors++; $display("FAIL p32_neg_minpos: got ok=%b s=%h exp=%h mant=%h nar=%h want 1 f fff88 80000000000000000 0",
                         ok, s, exp, mant, nar);
    end
    @(negedge clk);
  endtask

  // scripted=1: continuous input with a 3-cycle output stall; scripted=0: random valid/ready.
  task automatic test_stream(input int n, input bit scripted);
    int sent, got, c;
    bit have, stalled, saw_block;
    logic [1:0] p;
    logic [31:0] d;
    logic [RW-1:0] cur, prev, e;
    sent = 0; got = 0; c = 0; have = 0; stalled = 0; saw_block = 0;
    p = '0; d = '0; prev = '0;
    while (got < n && c < 4000) begin
      out_ready = scripted ? !(c >= 3 && c < 6) : ($urandom_range(0, 9) < 7);
      if (!have && sent < n && (scripted || $urandom_range(0, 3) != 0)) begin
        p = 2'($urandom_range(0, 3));
        d = rand_word();
        have = 1'b1;
      end
      in_valid = have;
      in_pre   = p;
      in_data  = d;
      #1;
      cur = dut_res();
      if (stalled) begin
        checks++;
        if (!out_valid || cur !== prev) begin
          errors++; $display("FAIL stream_hold: got v=%b %h want v=1 %h", out_valid, cur, prev);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_spurious: got %h want no output", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin errors++; $display("FAIL stream_data: got %h want %h", cur, e); end
        end
        got++;
      end
      if (have && !in_ready) saw_block = 1'b1;
      if (have && in_ready) begin
        exp_q.push_back(expect_word(p, d));
        sent++;
        have = 1'b0;
      end
      stalled = out_valid && !out_ready;
      prev = cur;
      @(posedge clk);
      @(negedge clk);
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != n || sent != n || exp_q.size() != 0) begin
      errors++; $display("FAIL stream_count: got sent=%0d recv=%0d left=%0d want %0d %0d 0", sent, got, exp_q.size(), n, n);
    end
    if (scripted) begin
      checks++;
      if (!saw_block) begin errors++; $display("FAIL stream_in_ready: got never low want low during stall"); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_stream();
    int lat; bit ok;
    logic [1:0] p;
    logic [31:0] d;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pre  = 2'($urandom_range(0, 3));
      in_data = $urandom;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_full: got out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_res() !== res_t'(0)) begin
      errors++; $display("FAIL mid_reset: got out_valid=%b in_ready=%b data=%h want 0 1 0", out_valid, in_ready, dut_res());
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_partial: got %b want 0 at cycle %0d", out_valid, i); end
    end
    p = 2'($urandom_range(0, 3));
    d = rand_word();
    run_single(p, d, lat, ok);
    checks++;
    if (!ok || lat != 2) begin errors++; $display("FAIL mid_first_latency: got ok=%b lat=%0d want 1 2", ok, lat); end
    checks++;
    if (dut_res() !== expect_word(p, d)) begin
      errors++; $display("FAIL mid_first_data: got %h want %h", dut_res(), expect_word(p, d));
    end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_p8_vector();
    test_p16_vector();
    test_p32_minpos();
    test_stream(5, 1'b1);
    test_stream(150, 1'b0);
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
